// File: rtl/dom_sbox_pkg.sv
// Shared constants and types for the DOM GF(2^2) stage controller.
// Holds LFSR taps, seed fixup, FSM states and FIFO depth.
package dom_sbox_pkg;

  // Galois right-shift taps for x^32+x^22+x^2+x+1
  localparam logic [31:0] LFSR_TAPS  = 32'h8020_0003;
  localparam logic [31:0] SEED_ZREPL = 32'h0000_0001;
  localparam int          FIFO_DEPTH = 2;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FLUSH = 2'd2
  } state_e;

  function automatic logic [31:0] lfsr_step(
    input logic [31:0] s
  );
    lfsr_step = {1'b0, s[31:1]} ^ (s[0] ? LFSR_TAPS : 32'h0);
  endfunction

endpackage

// File: rtl/dom_gf2_stage_ctrl_if.sv
// Operand and result streams of the DOM GF(2^2) stage controller.
// The slave side is the controller, the master side the environment.
interface dom_gf2_stage_ctrl_if #(
  parameter int SHARES = 2
);
  localparam int W = 2 * SHARES;

  logic         InValidxSI;
  logic         InReadyxSO;
  logic [W-1:0] InXxDI;
  logic [W-1:0] InBxDI;
  logic [W-1:0] InYxDI;
  logic         OutValidxSO;
  logic         OutReadyxSI;
  logic [W-1:0] OutQxDO;

  modport slave (
    input  InValidxSI, InXxDI, InBxDI, InYxDI,
    input  OutReadyxSI,
    output InReadyxSO, OutValidxSO, OutQxDO
  );

  modport master (
    output InValidxSI, InXxDI, InBxDI, InYxDI,
    output OutReadyxSI,
    input  InReadyxSO, OutValidxSO, OutQxDO
  );

endinterface

// File: rtl/dom_mask_lfsr.sv
// Fresh-mask source: 32-bit Galois LFSR advancing Z_W steps per enable.
// Low Z_W bits of the current state are the masks for this issue.
module dom_mask_lfsr
  import dom_sbox_pkg::*;
#(
  parameter int Z_W = 2
) (
  input  logic           ClkxCI,
  input  logic           RstxBI,
  input  logic           LoadxSI,
  input  logic [31:0]    SeedxDI,
  input  logic           EnxSI,
  output logic [Z_W-1:0] ZxDO
);

  logic [31:0] lfsr_q;
  logic [31:0] lfsr_d;
  logic [31:0] adv;

  always_comb begin
    adv = lfsr_q;
    for (int i = 0; i < Z_W; i++) begin
      adv = lfsr_step(adv);
    end
    lfsr_d = lfsr_q;
    if (LoadxSI) begin
      // all-zero state would lock the LFSR
      lfsr_d = (SeedxDI == 32'h0) ? SEED_ZREPL : SeedxDI;
    end else if (EnxSI) begin
      lfsr_d = adv;
    end
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      lfsr_q <= 32'h0;
    end else begin
      lfsr_q <= lfsr_d;
    end
  end

  assign ZxDO = lfsr_q[Z_W-1:0];

endmodule

// File: rtl/dom_gf2_stage_ctrl.sv
// Sequencer for one shared DOM GF(2^2) gadget: issue, fresh masks,
// one-cycle capture into a 2-entry credit-controlled output FIFO.
module dom_gf2_stage_ctrl
  import dom_sbox_pkg::*;
#(
  parameter  int SHARES = 2,
  parameter  int CNT_W  = 16,
  localparam int W      = 2 * SHARES,
  localparam int Z_W    = SHARES * (SHARES - 1)
) (
  input  logic             ClkxCI,
  input  logic             RstxBI,
  input  logic [31:0]      SeedxDI,
  input  logic             SeedValidxSI,
  input  logic             FlushxSI,
  dom_gf2_stage_ctrl_if.slave io,
  output logic [W-1:0]     GadXxDO,
  output logic [W-1:0]     GadBxDO,
  output logic [W-1:0]     GadYxDO,
  output logic [Z_W-1:0]   GadZxDO,
  input  logic [W-1:0]     GadQxDI,
  output logic             BusyxSO,
  output logic [CNT_W-1:0] DoneCntxDO
);

  state_e                            state_q, state_d;
  logic                              inflight_q, inflight_d;
  logic [1:0]                        cnt_q, cnt_d;
  logic                              wr_q, wr_d;
  logic                              rd_q, rd_d;
  logic [FIFO_DEPTH-1:0][W-1:0]      mem_q, mem_d;
  logic [CNT_W-1:0]                  done_q, done_d;

  logic       pop;
  logic       push;
  logic [2:0] credit;
  logic       in_ready;
  logic       issue;
  logic       seed_load;
  logic       out_valid;

  always_comb begin
    out_valid = (cnt_q != 2'd0);
    pop       = out_valid && io.OutReadyxSI;
    push      = inflight_q;
    // slot freed by a pop this cycle is reusable right away
    credit    = {1'b0, cnt_q} + {2'b0, inflight_q} - {2'b0, pop};
    in_ready  = (state_q == RUN) && (credit < 3'(FIFO_DEPTH));
    issue     = io.InValidxSI && in_ready;
    seed_load = (state_q == IDLE) && SeedValidxSI;

    state_d = state_q;
    unique case (state_q)
      IDLE:    if (SeedValidxSI) state_d = RUN;
      RUN:     if (FlushxSI) state_d = FLUSH;
      FLUSH:   if (!inflight_q && (cnt_q == 2'd0)) state_d = IDLE;
      default: state_d = IDLE;
    endcase

    inflight_d = issue;
    cnt_d      = cnt_q + {1'b0, push} - {1'b0, pop};
    wr_d       = wr_q ^ push;
    rd_d       = rd_q ^ pop;
    mem_d      = mem_q;
    if (push) begin
      mem_d[wr_q] = GadQxDI;
    end
    done_d = done_q + CNT_W'(pop);
  end

  always_ff @(posedge ClkxCI or negedge RstxBI) begin
    if (!RstxBI) begin
      state_q    <= IDLE;
      inflight_q <= 1'b0;
      cnt_q      <= 2'd0;
      wr_q       <= 1'b0;
      rd_q       <= 1'b0;
      mem_q      <= '0;
      done_q     <= '0;
    end else begin
      assert (!(push && !pop && (cnt_q == 2'(FIFO_DEPTH))));
      state_q    <= state_d;
      inflight_q <= inflight_d;
      cnt_q      <= cnt_d;
      wr_q       <= wr_d;
      rd_q       <= rd_d;
      mem_q      <= mem_d;
      done_q     <= done_d;
    end
  end

  dom_mask_lfsr #(
    .Z_W (Z_W)
  ) u_lfsr (
    .ClkxCI  (ClkxCI),
    .RstxBI  (RstxBI),
    .LoadxSI (seed_load),
    .SeedxDI (SeedxDI),
    .EnxSI   (issue),
    .ZxDO    (GadZxDO)
  );

  // idle gadget inputs held at zero to avoid data-dependent toggling
  assign GadXxDO = io.InXxDI & {W{issue}};
  assign GadBxDO = io.InBxDI & {W{issue}};
  assign GadYxDO = io.InYxDI & {W{issue}};

  assign io.InReadyxSO  = in_ready;
  assign io.OutValidxSO = out_valid;
  assign io.OutQxDO     = out_valid ? mem_q[rd_q] : '0;
  assign BusyxSO    = (state_q != IDLE) || inflight_q || out_valid;
  assign DoneCntxDO = done_q;

endmodule

// File: tb/tb_dom_gf2_stage_ctrl.sv
// Directed bench for dom_gf2_stage_ctrl with SHARES = 3 and a
// registered XOR stub standing in for the gadget.
module tb_dom_gf2_stage_ctrl;

  localparam int SHARES = 3;
  localparam int W      = 2 * SHARES;
  localparam int ZW     = SHARES * (SHARES - 1);
  localparam int CNT_W  = 16;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic [31:0]      seed;
  logic             seed_v;
  logic             flush;
  logic [W-1:0]     gx, gb, gy, gq;
  logic [ZW-1:0]    gz;
  logic             busy;
  logic [CNT_W-1:0] done;

  dom_gf2_stage_ctrl_if #(.SHARES(SHARES)) io ();

  dom_gf2_stage_ctrl #(
    .SHARES (SHARES),
    .CNT_W  (CNT_W)
  ) dut (
    .ClkxCI       (clk),
    .RstxBI       (rst_n),
    .SeedxDI      (seed),
    .SeedValidxSI (seed_v),
    .FlushxSI     (flush),
    .io           (io.slave),
    .GadXxDO      (gx),
    .GadBxDO      (gb),
    .GadYxDO      (gy),
    .GadZxDO      (gz),
    .GadQxDI      (gq),
    .BusyxSO      (busy),
    .DoneCntxDO   (done)
  );

  initial forever #5 clk = ~clk;

  always @(posedge clk) gq <= gx ^ gb ^ gy;

  initial begin
    #200000;
    $display("FAIL watchdog: time limit expired");
    $fatal(1, "timeout");
  end

  int          n_chk  = 0;
  int          n_pass = 0;
  logic [31:0] ref_q;
  logic        s1v, s2v;
  logic [W-1:0] s1d, s2d;

  task automatic chk(input string tag, input logic [31:0] obs,
                     input logic [31:0] exp);
    n_chk++;
    assert (obs === exp) n_pass++;
    else $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
  endtask

  // independent bit-level form of the Galois step
  function automatic logic [31:0] ref_step(input logic [31:0] s);
    logic [31:0] n;
    n = s >> 1;
    if (s[0]) begin
      n[31] = 1'b1;
      n[21] = ~n[21];
      n[1]  = ~n[1];
      n[0]  = ~n[0];
    end
    return n;
  endfunction

  function automatic logic [31:0] ref_adv(input logic [31:0] s);
    logic [31:0] t;
    t = s;
    for (int i = 0; i < ZW; i++) t = ref_step(t);
    return t;
  endfunction

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  // one cycle with OutReady=1; pipeline model predicts t+2 delivery
  task automatic stream_cyc(input bit v, input logic [W-1:0] x,
                            input logic [W-1:0] b, input logic [W-1:0] y);
    io.InValidxSI = v;
    io.InXxDI = x;
    io.InBxDI = b;
    io.InYxDI = y;
    io.OutReadyxSI = 1'b1;
    #2;
    chk("st_gadz", gz, ref_q[ZW-1:0]);
    if (v) begin
      chk("st_inready", io.InReadyxSO, 1);
      chk("st_gadx", gx, x);
      chk("st_gady", gy, y);
    end else begin
      chk("st_gadx_gated", gx, 0);
    end
    chk("st_outvalid", io.OutValidxSO, s2v);
    if (s2v) chk("st_outq", io.OutQxDO, s2d);
    s2v = s1v;
    s2d = s1d;
    s1v = v;
    s1d = x ^ b ^ y;
    if (v) ref_q = ref_adv(ref_q);
    cyc();
  endtask

  initial begin
    seed = 32'h0;
    seed_v = 1'b0;
    flush = 1'b0;
    io.InValidxSI = 1'b0;
    io.InXxDI = '0;
    io.InBxDI = '0;
    io.InYxDI = '0;
    io.OutReadyxSI = 1'b0;
    s1v = 1'b0; s2v = 1'b0; s1d = '0; s2d = '0;
    #3;
    chk("rst_inready", io.InReadyxSO, 0);
    chk("rst_outvalid", io.OutValidxSO, 0);
    chk("rst_outq", io.OutQxDO, 0);
    chk("rst_busy", busy, 0);
    chk("rst_gadz", gz, 0);
    chk("rst_done", done, 0);
    #4 rst_n = 1'b1;
    cyc();

    // no seed yet: requests are refused
    io.InValidxSI = 1'b1;
    io.InXxDI = 6'h15; io.InBxDI = 6'h2A; io.InYxDI = 6'h0F;
    #2;
    chk("noseed_inready", io.InReadyxSO, 0);
    chk("noseed_gadx", gx, 0);
    chk("noseed_busy", busy, 0);
    cyc();
    #2;
    chk("noseed_inready2", io.InReadyxSO, 0);
    cyc();

    io.InValidxSI = 1'b0;
    seed = 32'hACE1_2345;
    seed_v = 1'b1;
    #2;
    chk("seed_busy_idle", busy, 0);
    cyc();
    seed_v = 1'b0;
    ref_q = 32'hACE1_2345;
    #2;
    chk("seed_busy_run", busy, 1);
    chk("seed_first_gadz", gz, 6'h05);
    chk("seed_inready", io.InReadyxSO, 1);
    cyc();

    // back-to-back burst of 8
    for (int c = 0; c < 8; c++)
      stream_cyc(1'b1, W'(c * 7 + 1), W'(c * 13 + 5), W'(c * 3 + 9));
    for (int c = 0; c < 3; c++)
      stream_cyc(1'b0, 6'h3F, 6'h3F, 6'h3F);
    #2;
    chk("burst_done", done, 8);
    cyc();

    // backpressure: two issued, then credit exhausted
    io.OutReadyxSI = 1'b0;
    for (int c = 0; c < 5; c++) begin
      io.InValidxSI = 1'b1;
      io.InXxDI = (c == 0) ? 6'h21 : (c == 1) ? 6'h3F : 6'h11;
      io.InBxDI = (c == 0) ? 6'h0C : (c == 1) ? 6'h2A : 6'h22;
      io.InYxDI = (c == 0) ? 6'h33 : (c == 1) ? 6'h01 : 6'h04;
      #2;
      chk("bp_inready", io.InReadyxSO, (c < 2) ? 1 : 0);
      chk("bp_gadz", gz, ref_q[ZW-1:0]);
      chk("bp_outvalid", io.OutValidxSO, (c >= 2) ? 1 : 0);
      if (c >= 2) begin
        chk("bp_outq_hold", io.OutQxDO, 6'h1E);
        chk("bp_gadx_gated", gx, 0);
      end
      if (c < 2) ref_q = ref_adv(ref_q);
      cyc();
    end
    io.InValidxSI = 1'b0;
    io.OutReadyxSI = 1'b1;
    #2;
    chk("bp_rel_q0", io.OutQxDO, 6'h1E);
    chk("bp_rel_inready", io.InReadyxSO, 1);
    cyc();
    #2;
    chk("bp_rel_v1", io.OutValidxSO, 1);
    chk("bp_rel_q1", io.OutQxDO, 6'h14);
    cyc();
    #2;
    chk("bp_rel_empty", io.OutValidxSO, 0);
    chk("bp_done", done, 10);
    cyc();

    // 100 issues with idle gaps: masks never reused, frozen in gaps
    s1v = 1'b0; s2v = 1'b0;
    for (int k = 0; k < 100; k++) begin
      if (k % 10 == 9) stream_cyc(1'b0, 6'h2B, 6'h1C, 6'h35);
      stream_cyc(1'b1, W'(k * 5 + 3), W'(k * 11), W'(k ^ 6'h2D));
    end
    stream_cyc(1'b0, 6'h01, 6'h02, 6'h04);
    stream_cyc(1'b0, 6'h01, 6'h02, 6'h04);
    #2;
    chk("fresh_done", done, 110);
    cyc();

    // flush in the same cycle as an issue
    io.InValidxSI = 1'b1;
    io.InXxDI = 6'h07; io.InBxDI = 6'h38; io.InYxDI = 6'h12;
    flush = 1'b1;
    #2;
    chk("fl_issue_ready", io.InReadyxSO, 1);
    chk("fl_gadz", gz, ref_q[ZW-1:0]);
    ref_q = ref_adv(ref_q);
    cyc();
    flush = 1'b0;
    #2;
    chk("fl_inready_off", io.InReadyxSO, 0);
    chk("fl_busy1", busy, 1);
    cyc();
    #2;
    chk("fl_outvalid", io.OutValidxSO, 1);
    chk("fl_outq", io.OutQxDO, 6'h2D);
    cyc();
    #2;
    chk("fl_empty", io.OutValidxSO, 0);
    chk("fl_busy_last", busy, 1);
    cyc();
    #2;
    chk("fl_idle_busy", busy, 0);
    chk("fl_idle_inready", io.InReadyxSO, 0);
    chk("fl_done", done, 111);
    cyc();

    // zero seed behaves as seed 1; seed ignored while running
    io.InValidxSI = 1'b0;
    seed = 32'h0;
    seed_v = 1'b1;
    cyc();
    seed_v = 1'b0;
    ref_q = 32'h1;
    io.InValidxSI = 1'b1;
    #2;
    chk("z_inready", io.InReadyxSO, 1);
    chk("z_gadz0", gz, 6'h01);
    cyc();
    seed = 32'hFFFF_FFFF;
    seed_v = 1'b1;
    #2;
    chk("z_gadz1", gz, 6'h01);
    cyc();
    seed_v = 1'b0;
    io.InValidxSI = 1'b0;
    ref_q = ref_adv(ref_adv(ref_q));
    #2;
    chk("z_gadz2", gz, ref_q[ZW-1:0]);
    cyc();
    cyc();
    cyc();

    // async reset with two results buffered
    io.OutReadyxSI = 1'b0;
    io.InValidxSI = 1'b1;
    cyc();
    cyc();
    io.InValidxSI = 1'b0;
    cyc();
    #2;
    chk("ar_pre_valid", io.OutValidxSO, 1);
    chk("ar_pre_inready", io.InReadyxSO, 0);
    rst_n = 1'b0;
    #1;
    chk("ar_outvalid", io.OutValidxSO, 0);
    chk("ar_outq", io.OutQxDO, 0);
    chk("ar_busy", busy, 0);
    chk("ar_done", done, 0);
    chk("ar_gadz", gz, 0);
    #5 rst_n = 1'b1;
    io.InValidxSI = 1'b1;
    cyc();
    #2;
    chk("ar_need_seed", io.InReadyxSO, 0);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
